// File: rtl/rgb_matrix_pwm_scan.sv
// RGB LED matrix driver: double-buffered pixel store, one-row-at-a-time scan with blanking and
// per-column PWM. Buffers exchange only after the last row so a frame is never shown half old, half new.
module rgb_matrix_pwm_scan #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 64,
  parameter int BLANK    = 2,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [RW-1:0]         wr_row_i,
  input  logic [CW-1:0]         wr_col_i,
  input  logic [3*PWM_BITS-1:0] wr_rgb_i,
  input  logic                  swap_req_i,
  output logic                  swap_ack_o,
  output logic                  swap_pending_o,
  output logic [ROWS-1:0]       row_n_o,
  output logic [COLS-1:0]       col_r_o,
  output logic [COLS-1:0]       col_g_o,
  output logic [COLS-1:0]       col_b_o,
  output logic                  frame_start_o
);
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW  = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [PSW-1:0]      PRESC_LAST = PSW'(PRESCALE - 1);
  localparam logic [BW-1:0]       BLANK_LAST = BW'(BLANK - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [RW-1:0]       ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [PSW-1:0]      presc_q, presc_d;
  logic [BW-1:0]       blank_q, blank_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [RW-1:0]       row_q, row_d;
  logic                front_q, front_d;
  logic                pending_q, pending_d;

  logic [ROWS-1:0]     row_n_q, row_n_d;
  logic [COLS-1:0]     col_r_q, col_r_d;
  logic [COLS-1:0]     col_g_q, col_g_d;
  logic [COLS-1:0]     col_b_q, col_b_d;
  logic                swap_ack_q, swap_ack_d;
  logic                frame_start_q, frame_start_d;

  logic [3*PWM_BITS-1:0] pix_q [2][ROWS][COLS];

  logic tick, drive, boundary, do_swap, wr_hit, back_sel;

  assign tick     = (presc_q == PRESC_LAST);
  assign drive    = (state_q == ST_DRIVE);
  assign boundary = tick && drive && (pwm_q == PWM_LAST) && (row_q == ROW_LAST);
  assign do_swap  = boundary && (pending_q || swap_req_i);
  assign back_sel = ~front_q;
  assign wr_hit   = wr_en_i && (int'(wr_row_i) < ROWS) && (int'(wr_col_i) < COLS);

  // Pixel store; writes always go to whichever buffer is back in the current cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            pix_q[b][r][c] <= '0;
    end else if (wr_hit) begin
      pix_q[back_sel][wr_row_i][wr_col_i] <= wr_rgb_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      presc_q       <= '0;
      blank_q       <= '0;
      pwm_q         <= '0;
      row_q         <= '0;
      front_q       <= 1'b0;
      pending_q     <= 1'b0;
      row_n_q       <= '1;
      col_r_q       <= '0;
      col_g_q       <= '0;
      col_b_q       <= '0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      blank_q       <= blank_d;
      pwm_q         <= pwm_d;
      row_q         <= row_d;
      front_q       <= front_d;
      pending_q     <= pending_d;
      row_n_q       <= row_n_d;
      col_r_q       <= col_r_d;
      col_g_q       <= col_g_d;
      col_b_q       <= col_b_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    pwm_d   = pwm_q;
    row_d   = row_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    if (tick) begin
      if (state_q == ST_BLANK) begin
        if (blank_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          blank_d = '0;
          pwm_d   = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end else begin
        if (pwm_q == PWM_LAST) begin
          state_d = ST_BLANK;
          row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          pwm_d = pwm_q + 1'b1;
        end
      end
    end
    // A request arriving on the swapping cycle itself is consumed by that swap
    front_d   = front_q ^ do_swap;
    pending_d = do_swap ? 1'b0 : (pending_q || swap_req_i);
  end

  always_comb begin
    row_n_d = '1;
    if (drive)
      row_n_d[row_q] = 1'b0;
    swap_ack_d    = do_swap;
    frame_start_d = drive && (row_q == '0) && (pwm_q == '0) && (presc_q == '0);
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    logic [3*PWM_BITS-1:0] pix;
    assign pix         = pix_q[front_q][row_q][gi];
    assign col_r_d[gi] = drive && (pix[3*PWM_BITS-1:2*PWM_BITS] > pwm_q);
    assign col_g_d[gi] = drive && (pix[2*PWM_BITS-1:PWM_BITS] > pwm_q);
    assign col_b_d[gi] = drive && (pix[PWM_BITS-1:0] > pwm_q);
  end

  assign row_n_o        = row_n_q;
  assign col_r_o        = col_r_q;
  assign col_g_o        = col_g_q;
  assign col_b_o        = col_b_q;
  assign swap_ack_o     = swap_ack_q;
  assign swap_pending_o = pending_q;
  assign frame_start_o  = frame_start_q;

endmodule
